// File: rtl/char_pkg.sv
// Shared ASCII constants and tracker state encoding for the character normalizer.
package char_pkg;

  localparam logic [7:0] SPACE       = 8'h20;
  localparam logic [7:0] TAB         = 8'h09;
  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] NUL         = 8'h00;
  localparam logic [7:0] UPPER_A     = 8'h41;
  localparam logic [7:0] UPPER_Z     = 8'h5A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // WS: last forwarded byte was a space (or nothing forwarded since reset).
  typedef enum logic {
    TRK_WS   = 1'b0,
    TRK_WORD = 1'b1
  } tracker_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; head is shown combinationally, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same address bits with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/char_normalizer.sv
// Byte normalizer: case folding, whitespace mapping, NUL drop, optional space collapse.
// Optional feature macro: CHAR_NORMALIZER_COLLAPSE_WS_EN (drop spaces while tracker is WS).
//
// Handshake: a byte moves on a rising edge where valid && ready are both high; the
// source holds data stable while valid is high and ready is low; ready never depends
// combinationally on the same-side valid, and in_ready never depends on out_ready.
module char_normalizer
  import char_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [7:0]                  out_data,
  input  logic                        out_ready,
  output logic [15:0]                 drop_cnt,
  output tracker_e                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_level
);

  tracker_e    state_q, state_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        is_upper;
  logic        is_ws;
  logic        is_nul;
  logic [7:0]  mapped;
  logic        accept;
  logic        collapse_drop;
  logic        forward;
  logic        drop;

  assign is_upper = (in_data >= UPPER_A) && (in_data <= UPPER_Z);
  assign is_ws    = (in_data == TAB) || (in_data == LF) ||
                    (in_data == CR)  || (in_data == SPACE);
  assign is_nul   = (in_data == NUL);

  always_comb begin
    mapped = in_data;
    if (is_upper)   mapped = in_data + CASE_OFFSET;
    else if (is_ws) mapped = SPACE;
  end

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

`ifdef CHAR_NORMALIZER_COLLAPSE_WS_EN
  assign collapse_drop = is_ws && (state_q == TRK_WS);
`else
  assign collapse_drop = 1'b0;
`endif

  assign forward = accept && !is_nul && !collapse_drop;
  assign drop    = accept && !forward;

  // Tracker: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= TRK_WS;
    else       state_q <= state_d;
  end

  // Tracker: next state; dropped bytes leave it untouched
  always_comb begin
    state_d = state_q;
    if (forward) state_d = (mapped == SPACE) ? TRK_WS : TRK_WORD;
  end

  // Tracker: outputs
  always_comb begin
    dbg_state = state_q;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt  = drop_cnt_q;
  assign out_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (forward),
    .push_data_i (mapped),
    .pop_i       (out_ready),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (dbg_level)
  );

endmodule
